// File: rtl/video_if.sv
// Video timing/pattern bus: control inputs to the generator and the raster/pixel outputs it produces.
interface video_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          en;
    logic [1:0]    mode;
    logic [7:0]    red_on;
    logic [7:0]    red_off;
    logic [7:0]    green_on;
    logic [7:0]    green_off;
    logic [7:0]    blue_on;
    logic [7:0]    blue_off;
    logic          hSync;
    logic          vSync;
    logic          drawArea;
    logic          frame_start;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;

    modport master (
        input  en, mode, red_on, red_off, green_on, green_off, blue_on, blue_off,
        output hSync, vSync, drawArea, frame_start, pix_x, pix_y, red, green, blue
    );

    modport slave (
        output en, mode, red_on, red_off, green_on, green_off, blue_on, blue_off,
        input  hSync, vSync, drawArea, frame_start, pix_x, pix_y, red, green, blue
    );
endinterface

// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with a four-pattern test source; every output is registered one cycle after the counters.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int BAR_W    = 80,
    parameter int CHK_LOG2 = 5
) (
    input logic    clk,
    input logic    rst,
    video_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FRONT);
    localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FRONT);
    localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic [1:0]    mode_q;

    logic          frame_origin;
    logic          active;
    logic          hs_on;
    logic          vs_on;
    logic [1:0]    mode_eff;
    logic          sel_r;
    logic          sel_g;
    logic          sel_b;
    logic [7:0]    r_nxt;
    logic [7:0]    g_nxt;
    logic [7:0]    b_nxt;

    always_comb begin
        frame_origin = (h_cnt == '0) && (v_cnt == '0);
        active       = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_on        = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        vs_on        = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        // The first pixel of a frame already shows the newly sampled mode.
        mode_eff     = frame_origin ? vif.mode : mode_q;
        sel_r        = 1'b1;
        sel_g        = 1'b1;
        sel_b        = 1'b1;
        case (mode_eff)
            2'd0: begin
                sel_r = bar_idx[0];
                sel_g = bar_idx[1];
                sel_b = bar_idx[2];
            end
            2'd1: begin
                sel_r = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
                sel_g = sel_r;
                sel_b = sel_r;
            end
            default: ;
        endcase
        r_nxt = sel_r ? vif.red_on   : vif.red_off;
        g_nxt = sel_g ? vif.green_on : vif.green_off;
        b_nxt = sel_b ? vif.blue_on  : vif.blue_off;
        if (mode_eff == 2'd3) begin
            r_nxt = h_cnt[7:0];
            g_nxt = h_cnt[7:0];
            b_nxt = h_cnt[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bar_cnt         <= '0;
            bar_idx         <= '0;
            mode_q          <= '0;
            vif.hSync       <= ~HS_POL;
            vif.vSync       <= ~VS_POL;
            vif.drawArea    <= 1'b0;
            vif.frame_start <= 1'b0;
            vif.pix_x       <= '0;
            vif.pix_y       <= '0;
            vif.red         <= '0;
            vif.green       <= '0;
            vif.blue        <= '0;
        end else if (!vif.en) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bar_cnt         <= '0;
            bar_idx         <= '0;
            vif.hSync       <= ~HS_POL;
            vif.vSync       <= ~VS_POL;
            vif.drawArea    <= 1'b0;
            vif.frame_start <= 1'b0;
            vif.pix_x       <= '0;
            vif.pix_y       <= '0;
            vif.red         <= '0;
            vif.green       <= '0;
            vif.blue        <= '0;
        end else begin
            vif.hSync       <= hs_on ? HS_POL : ~HS_POL;
            vif.vSync       <= vs_on ? VS_POL : ~VS_POL;
            vif.drawArea    <= active;
            vif.frame_start <= frame_origin;
            vif.pix_x       <= active ? h_cnt : '0;
            vif.pix_y       <= active ? v_cnt : '0;
            vif.red         <= active ? r_nxt : '0;
            vif.green       <= active ? g_nxt : '0;
            vif.blue        <= active ? b_nxt : '0;
            if (frame_origin)
                mode_q <= vif.mode;
            // Bar counters track h_cnt so the bar index needs no divider.
            if (h_cnt == H_LAST) begin
                h_cnt   <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_cnt <= bar_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen on a reduced raster, checked against an arithmetic frame-position model.
module tb_video_timing_pattern_gen;
    localparam int H_ACTIVE = 270;
    localparam int H_FRONT  = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BACK   = 5;
    localparam int V_ACTIVE = 12;
    localparam int V_FRONT  = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 3;
    localparam bit HS_POL   = 1'b0;
    localparam bit VS_POL   = 1'b1;
    localparam int BAR_W    = 30;
    localparam int CHK_LOG2 = 3;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int XW       = $clog2(H_TOTAL);
    localparam int YW       = $clog2(V_TOTAL);
    localparam int VW       = 4 + XW + YW + 24;
    localparam logic [VW-1:0] BLANK_V = {!HS_POL, !VS_POL, {(VW-2){1'b0}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    video_if #(.XW(XW), .YW(YW)) vif ();

    video_timing_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .BAR_W(BAR_W), .CHK_LOG2(CHK_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vif(vif)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] act_v;
    assign act_v = {vif.hSync, vif.vSync, vif.drawArea, vif.frame_start, vif.pix_x, vif.pix_y,
                    vif.red, vif.green, vif.blue};

    // Reference: position inside the frame since the last restart, decoded with plain arithmetic.
    logic [VW-1:0] exp_v;
    int            pos;
    int            m_x, m_y, m_idx;
    logic [1:0]    m_mode;
    logic          m_act, m_hs, m_vs, m_bit;
    logic [7:0]    m_r, m_g, m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos    = 0;
            m_mode = 2'd0;
            exp_v  = BLANK_V;
        end else if (!vif.en) begin
            pos   = 0;
            exp_v = BLANK_V;
        end else begin
            m_x = pos % H_TOTAL;
            m_y = pos / H_TOTAL;
            if (pos == 0) m_mode = vif.mode;
            m_act = (m_x < H_ACTIVE) && (m_y < V_ACTIVE);
            m_hs  = (m_x >= H_ACTIVE + H_FRONT && m_x < H_ACTIVE + H_FRONT + H_SYNC) ? HS_POL : !HS_POL;
            m_vs  = (m_y >= V_ACTIVE + V_FRONT && m_y < V_ACTIVE + V_FRONT + V_SYNC) ? VS_POL : !VS_POL;
            m_r = 8'd0; m_g = 8'd0; m_b = 8'd0;
            if (m_act) begin
                case (m_mode)
                    2'd0: begin
                        m_idx = (m_x / BAR_W) % 8;
                        m_r = (m_idx % 2 == 1) ? vif.red_on : vif.red_off;
                        m_g = ((m_idx / 2) % 2 == 1) ? vif.green_on : vif.green_off;
                        m_b = (m_idx / 4 == 1) ? vif.blue_on : vif.blue_off;
                    end
                    2'd1: begin
                        m_bit = ((((m_x >> CHK_LOG2) ^ (m_y >> CHK_LOG2)) & 1) == 1);
                        m_r = m_bit ? vif.red_on : vif.red_off;
                        m_g = m_bit ? vif.green_on : vif.green_off;
                        m_b = m_bit ? vif.blue_on : vif.blue_off;
                    end
                    2'd2: begin
                        m_r = vif.red_on; m_g = vif.green_on; m_b = vif.blue_on;
                    end
                    default: begin
                        m_r = 8'(m_x % 256); m_g = 8'(m_x % 256); m_b = 8'(m_x % 256);
                    end
                endcase
            end
            exp_v = {m_hs, m_vs, m_act, (pos == 0),
                     m_act ? XW'(m_x) : XW'(0), m_act ? YW'(m_y) : YW'(0), m_r, m_g, m_b};
            pos = (pos + 1) % FRAME;
        end
    end

    task automatic set_levels();
        vif.red_on    = 8'($urandom);
        vif.red_off   = vif.red_on ^ 8'($urandom_range(1, 255));
        vif.green_on  = 8'($urandom);
        vif.green_off = vif.green_on ^ 8'($urandom_range(1, 255));
        vif.blue_on   = 8'($urandom);
        vif.blue_off  = vif.blue_on ^ 8'($urandom_range(1, 255));
    endtask

    task automatic restart();
        @(negedge clk) vif.en = 1'b0;
        @(negedge clk) vif.en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vif.en = 1'b1;
        vif.mode = 2'd0;
        set_levels();
        repeat (3) @(negedge clk);
        checks++;
        if (act_v !== BLANK_V) begin
            errors++; $display("FAIL reset_state got=%h want=%h", act_v, BLANK_V);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({vif.frame_start, vif.drawArea, vif.pix_x, vif.pix_y} !== {1'b1, 1'b1, XW'(0), YW'(0)}) begin
            errors++; $display("FAIL reset_first_pixel got fs=%b de=%b x=%0d y=%0d want fs=1 de=1 x=0 y=0",
                               vif.frame_start, vif.drawArea, vif.pix_x, vif.pix_y);
        end
        checks++;
        if (act_v !== exp_v) begin
            errors++; $display("FAIL reset_model got=%h want=%h", act_v, exp_v);
        end
    endtask

    task automatic test_timing();
        int fs_cnt = 0, fs_last = 0, de_cnt = 0, hs_run = 0, vs_run = 0, de_fall = -10 * H_TOTAL;
        logic p_hs = 1'b0, p_vs = 1'b0, p_de = 1'b0, hs_a, vs_a;
        vif.mode = 2'd0;
        restart();
        for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL timing_model cyc=%0d got=%h want=%h", cyc, act_v, exp_v);
            end
            if (vif.frame_start === 1'b1) begin
                if (fs_cnt > 0) begin
                    checks++;
                    if (cyc - fs_last != FRAME) begin
                        errors++; $display("FAIL frame_period got=%0d want=%0d", cyc - fs_last, FRAME);
                    end
                end
                fs_last = cyc;
                fs_cnt++;
            end
            if (vif.drawArea === 1'b1) de_cnt++;
            if (vif.drawArea !== 1'b1 && p_de) de_fall = cyc;
            hs_a = (vif.hSync === HS_POL);
            if (hs_a) begin
                if (!p_hs && (cyc - de_fall < H_TOTAL)) begin
                    checks++;
                    if (cyc - de_fall != H_FRONT) begin
                        errors++; $display("FAIL hsync_front got=%0d want=%0d", cyc - de_fall, H_FRONT);
                    end
                end
                hs_run++;
            end else if (p_hs) begin
                checks++;
                if (hs_run != H_SYNC) begin
                    errors++; $display("FAIL hsync_width got=%0d want=%0d", hs_run, H_SYNC);
                end
                hs_run = 0;
            end
            vs_a = (vif.vSync === VS_POL);
            if (vs_a) begin
                if (!p_vs) begin
                    checks++;
                    if (cyc - fs_last != (V_ACTIVE + V_FRONT) * H_TOTAL) begin
                        errors++; $display("FAIL vsync_start got=%0d want=%0d", cyc - fs_last,
                                           (V_ACTIVE + V_FRONT) * H_TOTAL);
                    end
                end
                vs_run++;
            end else if (p_vs) begin
                checks++;
                if (vs_run != V_SYNC * H_TOTAL) begin
                    errors++; $display("FAIL vsync_width got=%0d want=%0d", vs_run, V_SYNC * H_TOTAL);
                end
                vs_run = 0;
            end
            p_hs = hs_a;
            p_vs = vs_a;
            p_de = (vif.drawArea === 1'b1);
        end
        checks++;
        if (de_cnt != 2 * H_ACTIVE * V_ACTIVE) begin
            errors++; $display("FAIL de_count got=%0d want=%0d", de_cnt, 2 * H_ACTIVE * V_ACTIVE);
        end
        checks++;
        if (fs_cnt != 2) begin
            errors++; $display("FAIL frame_count got=%0d want=2", fs_cnt);
        end
    endtask

    task automatic test_bars();
        logic [23:0] off_c, on_c, red_c;
        set_levels();
        vif.mode = 2'd0;
        off_c = {vif.red_off, vif.green_off, vif.blue_off};
        on_c  = {vif.red_on, vif.green_on, vif.blue_on};
        red_c = {vif.red_on, vif.green_off, vif.blue_off};
        restart();
        for (int i = 0; i < H_ACTIVE; i++) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL bars_model x=%0d got=%h want=%h", i, act_v, exp_v);
            end
            if (i == 0 || i == BAR_W || i == 7 * BAR_W || i == 8 * BAR_W) begin
                checks++;
                if ({vif.red, vif.green, vif.blue} !== ((i == BAR_W) ? red_c : (i == 7 * BAR_W) ? on_c : off_c)) begin
                    errors++; $display("FAIL bars_spot x=%0d got=%h", i, {vif.red, vif.green, vif.blue});
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        set_levels();
        vif.mode = 2'd0;
        restart();
        for (int c = 0; c <= FRAME + (1 << CHK_LOG2); c++) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL switch_model c=%0d got=%h want=%h", c, act_v, exp_v);
            end
            if (c == 7 * H_TOTAL + BAR_W) begin
                checks++;
                if ({vif.red, vif.green, vif.blue} !== {vif.red_on, vif.green_off, vif.blue_off}) begin
                    errors++; $display("FAIL switch_no_tear got=%h want=%h", {vif.red, vif.green, vif.blue},
                                       {vif.red_on, vif.green_off, vif.blue_off});
                end
            end
            if (c == FRAME) begin
                checks++;
                if ({vif.frame_start, vif.red, vif.green, vif.blue} !== {1'b1, vif.red_off, vif.green_off, vif.blue_off}) begin
                    errors++; $display("FAIL switch_origin got=%h", {vif.frame_start, vif.red, vif.green, vif.blue});
                end
            end
            if (c == FRAME + (1 << CHK_LOG2)) begin
                checks++;
                if ({vif.red, vif.green, vif.blue} !== {vif.red_on, vif.green_on, vif.blue_on}) begin
                    errors++; $display("FAIL switch_checker got=%h want=%h", {vif.red, vif.green, vif.blue},
                                       {vif.red_on, vif.green_on, vif.blue_on});
                end
            end
            if (c == 6 * H_TOTAL + 10) vif.mode = 2'd1;
        end
    endtask

    task automatic test_en_drop();
        localparam int XD = 100;
        localparam int YD = 5;
        vif.mode = 2'($urandom);
        restart();
        for (int c = 0; c <= YD * H_TOTAL + XD; c++) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL endrop_model c=%0d got=%h want=%h", c, act_v, exp_v);
            end
        end
        checks++;
        if ({vif.pix_x, vif.pix_y} !== {XW'(XD), YW'(YD)}) begin
            errors++; $display("FAIL endrop_position got x=%0d y=%0d want x=%0d y=%0d", vif.pix_x, vif.pix_y, XD, YD);
        end
        vif.en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (act_v !== BLANK_V) begin
                errors++; $display("FAIL endrop_blank c=%0d got=%h want=%h", c, act_v, BLANK_V);
            end
        end
        vif.en = 1'b1;
        @(negedge clk);
        checks++;
        if ({vif.frame_start, vif.drawArea, vif.pix_x, vif.pix_y} !== {1'b1, 1'b1, XW'(0), YW'(0)}) begin
            errors++; $display("FAIL endrop_resume got fs=%b de=%b x=%0d y=%0d want fs=1 de=1 x=0 y=0",
                               vif.frame_start, vif.drawArea, vif.pix_x, vif.pix_y);
        end
        for (int c = 0; c < 2 * H_TOTAL; c++) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL endrop_after c=%0d got=%h want=%h", c, act_v, exp_v);
            end
        end
    endtask

    task automatic test_rst_mid();
        int stop = $urandom_range(H_TOTAL, FRAME - 1);
        vif.mode = 2'd2;
        restart();
        repeat (stop) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (act_v !== BLANK_V) begin
            errors++; $display("FAIL rst_async got=%h want=%h", act_v, BLANK_V);
        end
        vif.mode = 2'($urandom);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({vif.frame_start, vif.drawArea, vif.pix_x, vif.pix_y} !== {1'b1, 1'b1, XW'(0), YW'(0)}) begin
            errors++; $display("FAIL rst_release got fs=%b de=%b x=%0d y=%0d want fs=1 de=1 x=0 y=0",
                               vif.frame_start, vif.drawArea, vif.pix_x, vif.pix_y);
        end
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL rst_after c=%0d got=%h want=%h", c, act_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int en_low = 0;
        set_levels();
        restart();
        for (int c = 0; c < 4 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL random_model c=%0d got=%h want=%h", c, act_v, exp_v);
            end
            if ($urandom_range(0, 1499) == 0) vif.mode = 2'($urandom);
            if ($urandom_range(0, 699) == 0) set_levels();
            if (en_low > 0) begin
                en_low--;
                if (en_low == 0) vif.en = 1'b1;
            end else if ($urandom_range(0, 2499) == 0) begin
                en_low = $urandom_range(1, 4);
                vif.en = 1'b0;
            end
        end
        vif.en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_mode_switch();
        test_en_drop();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
